// File: rtl/psum_accumulator.sv
// Signed multiply-accumulate stage. A product register feeds an accumulator that emits one psum per cfg_len beats.
// Define PSUM_SATURATE_EN to make the accumulator add saturate instead of wrap.
module psum_accumulator #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [CNT_WIDTH-1:0]      cfg_len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     ifmap_data,
  input  logic [DATA_WIDTH-1:0]     filter_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*DATA_WIDTH-1:0]   psum_out,
  output logic                      busy
);

  localparam int PW = 2 * DATA_WIDTH;

  typedef enum logic {IDLE, ACCUM} state_e;

  state_e                state_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  len_q;
  logic [CNT_WIDTH-1:0]  lenEff;
  logic                  pValid_q;
  logic                  pFirst_q;
  logic                  pLast_q;
  logic signed [PW-1:0]  prod_q;
  logic signed [PW-1:0]  prod_d;
  logic signed [PW-1:0]  acc_q;
  logic signed [PW-1:0]  acc_d;
  logic signed [PW-1:0]  addSum;
  logic signed [PW-1:0]  opA;
  logic signed [PW-1:0]  opB;
  logic [PW-1:0]         psum_q;
  logic                  outValid_q;
  logic                  stall;
  logic                  accept;

  assign stall    = outValid_q && !out_ready;
  assign in_ready = !stall && !flush;
  assign accept   = in_valid && in_ready;
  assign lenEff   = (cfg_len == '0) ? CNT_WIDTH'(1) : cfg_len;

  // Operands are sign-extended first so the truncated product is exact.
  assign opA    = {{DATA_WIDTH{ifmap_data[DATA_WIDTH-1]}}, ifmap_data};
  assign opB    = {{DATA_WIDTH{filter_data[DATA_WIDTH-1]}}, filter_data};
  assign prod_d = opA * opB;

  always_comb begin
    addSum = acc_q + prod_q;
`ifdef PSUM_SATURATE_EN
    if ((acc_q[PW-1] == prod_q[PW-1]) && (addSum[PW-1] != acc_q[PW-1])) begin
      addSum = acc_q[PW-1] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
    end
`endif
    acc_d = pFirst_q ? prod_q : addSum;
  end

  // Stall freezes both pipeline stages and the beat FSM; flush clears them but leaves the output register alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      pValid_q   <= 1'b0;
      pFirst_q   <= 1'b0;
      pLast_q    <= 1'b0;
      prod_q     <= '0;
      acc_q      <= '0;
      psum_q     <= '0;
      outValid_q <= 1'b0;
    end else begin
      if (outValid_q && out_ready) begin
        outValid_q <= 1'b0;
      end
      if (flush) begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        pValid_q <= 1'b0;
        acc_q    <= '0;
      end else if (!stall) begin
        if (pValid_q) begin
          acc_q <= acc_d;
          if (pLast_q) begin
            outValid_q <= 1'b1;
            psum_q     <= acc_d;
          end
        end
        pValid_q <= accept;
        if (accept) begin
          prod_q <= prod_d;
          case (state_q)
            IDLE: begin
              len_q    <= lenEff;
              pFirst_q <= 1'b1;
              if (lenEff == CNT_WIDTH'(1)) begin
                pLast_q <= 1'b1;
              end else begin
                pLast_q <= 1'b0;
                cnt_q   <= CNT_WIDTH'(1);
                state_q <= ACCUM;
              end
            end
            ACCUM: begin
              pFirst_q <= 1'b0;
              if (cnt_q == len_q - CNT_WIDTH'(1)) begin
                pLast_q <= 1'b1;
                cnt_q   <= '0;
                state_q <= IDLE;
              end else begin
                pLast_q <= 1'b0;
                cnt_q   <= cnt_q + CNT_WIDTH'(1);
              end
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign out_valid = outValid_q;
  assign psum_out  = psum_q;
  assign busy      = (state_q == ACCUM) || pValid_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Testbench for psum_accumulator: table of psum vectors plus hand-written latency, stall, flush and reset sequences.
// Expected psums are queued when the last beat is driven and popped on each output handshake.
module tb_psum_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [7:0]  cfg_len;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] ifmap_data;
  logic [15:0] filter_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] psum_out;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] expQ[$];

  typedef struct packed {
    logic [7:0]        len;
    logic [2:0]        n;
    logic [3:0][15:0]  a;
    logic [3:0][15:0]  b;
    logic [31:0]       exp;
  } vecT;

  vecT vecs[8];

  psum_accumulator #(.DATA_WIDTH(16), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .flush(flush), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready),
    .ifmap_data(ifmap_data), .filter_data(filter_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .psum_out(psum_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drives one beat from #1 after a rising edge and returns #1 after the edge that accepted it.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic [7:0] len,
                               input bit last, input logic [31:0] exp);
    bit ok;
    bit accepted;
    in_valid    = 1'b1;
    ifmap_data  = a;
    filter_data = b;
    cfg_len     = len;
    if (last) expQ.push_back(exp);
    accepted = 1'b0;
    for (int t = 0; t < 200 && !accepted; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) accepted = 1'b1;
    end
    in_valid = 1'b0;
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL beat_timeout: got no acceptance expected acceptance within 200 cycles");
    end
  endtask

  function automatic vecT mkVec(input logic [7:0] len, input int n,
                                input logic [15:0] a0, input logic [15:0] b0,
                                input logic [15:0] a1, input logic [15:0] b1,
                                input logic [15:0] a2, input logic [15:0] b2,
                                input logic [15:0] a3, input logic [15:0] b3,
                                input logic [31:0] exp);
    vecT v;
    v.len = len;
    v.n   = 3'(n);
    v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
    v.exp = exp;
    return v;
  endfunction

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_psum: got %h expected no output", psum_out);
      end else begin
        checkOutput("psum", psum_out, expQ.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] satExp4;
    logic [31:0] satExp6;
`ifdef PSUM_SATURATE_EN
    satExp4 = 32'h7FFF_FFFF;
    satExp6 = 32'h8000_0000;
`else
    satExp4 = 32'h0000_0000;
    satExp6 = 32'h0002_0000;
`endif
    vecs[0] = mkVec(8'd3, 3, 16'd2, 16'd3, 16'hFFFC, 16'd5, 16'd7, 16'd1, 16'd0, 16'd0, 32'hFFFF_FFF9);
    vecs[1] = mkVec(8'd0, 1, 16'd100, 16'd100, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 32'd10000);
    vecs[2] = mkVec(8'd0, 1, 16'hFFFF, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 32'hFFFF_FFFF);
    vecs[3] = mkVec(8'd2, 2, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'd0, 16'd0, 16'd0, 16'd0, 32'h7FFE_0002);
    vecs[4] = mkVec(8'd4, 4, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, satExp4);
    vecs[5] = mkVec(8'd1, 1, 16'hFFF9, 16'd9, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 32'hFFFF_FFC1);
    vecs[6] = mkVec(8'd4, 4, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, satExp6);
    vecs[7] = mkVec(8'd3, 3, 16'd5, 16'hFFFD, 16'd0, 16'd1234, 16'hFFFE, 16'hFFFA, 16'd0, 16'd0, 32'hFFFF_FFFD);

    reset = 1'b1; flush = 1'b0; cfg_len = 8'd0; in_valid = 1'b0;
    ifmap_data = '0; filter_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_psum_out", psum_out, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    $display("[TB] latency: three-beat psum, out_valid for exactly one cycle");
    for (int j = 0; j < 3; j++)
      applyStimulus(vecs[0].a[j], vecs[0].b[j], 8'd3, j == 2, vecs[0].exp);
    @(negedge clk); checkOutput("lat_cycle1", {31'd0, out_valid}, 32'd0);
    @(negedge clk); checkOutput("lat_cycle2", {31'd0, out_valid}, 32'd1);
    @(negedge clk); checkOutput("lat_cycle3", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;

    $display("[TB] throughput: cfg_len=0 gives back-to-back single-beat psums");
    applyStimulus(16'd100, 16'd100, 8'd0, 1'b1, 32'd10000);
    applyStimulus(16'hFFFF, 16'd1, 8'd0, 1'b1, 32'hFFFF_FFFF);
    @(negedge clk); checkOutput("thru_first", {31'd0, out_valid}, 32'd1);
    @(negedge clk); checkOutput("thru_second", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;

    $display("[TB] table vectors, cfg_len scrambled after each first beat");
    for (int v = 0; v < 8; v++) begin
      for (int j = 0; j < int'(vecs[v].n); j++)
        applyStimulus(vecs[v].a[j], vecs[v].b[j], (j == 0) ? vecs[v].len : 8'($urandom_range(0, 255)),
                      j == int'(vecs[v].n) - 1, vecs[v].exp);
    end
    repeat (4) @(posedge clk); #1;

    $display("[TB] stall: out_ready low holds psum_out and blocks input");
    out_ready = 1'b0;
    fork
      begin
        applyStimulus(16'd1, 16'd2, 8'd2, 1'b0, 32'd0);
        applyStimulus(16'd3, 16'd4, 8'd2, 1'b1, 32'd14);
        applyStimulus(16'd5, 16'd6, 8'd2, 1'b0, 32'd0);
        applyStimulus(16'd7, 16'd8, 8'd2, 1'b1, 32'd86);
      end
      begin
        repeat (6) @(negedge clk);
        checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("stall_out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("stall_psum_hold", psum_out, 32'd14);
        @(negedge clk);
        checkOutput("stall_psum_hold2", psum_out, 32'd14);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk); #1;

    $display("[TB] flush: aborted beats leave no residue");
    applyStimulus(16'd9, 16'd9, 8'd4, 1'b0, 32'd0);
    applyStimulus(16'd5, 16'd5, 8'd4, 1'b0, 32'd0);
    flush = 1'b1;
    in_valid = 1'b1; ifmap_data = 16'd100; filter_data = 16'd100; cfg_len = 8'd1;
    @(negedge clk); checkOutput("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk); checkOutput("flush_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    for (int j = 0; j < 4; j++)
      applyStimulus(16'd1, 16'd1, 8'd4, j == 3, 32'd4);
    repeat (4) @(posedge clk); #1;

    $display("[TB] reset mid-psum discards the partial sum");
    applyStimulus(16'd9, 16'd9, 8'd3, 1'b0, 32'd0);
    applyStimulus(16'd9, 16'd9, 8'd3, 1'b0, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_mid_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    for (int j = 0; j < 3; j++)
      applyStimulus(16'd1, 16'd2, 8'd3, j == 2, 32'd6);

    for (int t = 0; t < 50 && expQ.size() != 0; t++) @(posedge clk);
    repeat (3) @(negedge clk);
    checkOutput("sb_drained", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
